// File: rtl/baccarat_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and constants for the baccarat hand sequencer.
//   state_t     : sequencer states in dealing / evaluation order
//   NATURAL_MIN : two-card total that ends the hand immediately
//   PLAYER_STAND_MIN : player (and, with two cards, banker) stands at or above
//   BANKER_STAND: banker never draws at this total
//   card_value  : raw rank (0 empty, 1..13) to baccarat point value 0..9
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [3:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        EVAL,
        DEAL_P3,
        BANK_EVAL,
        DEAL_D3,
        DONE
    } state_t;

    localparam logic [3:0] NATURAL_MIN      = 4'd8;
    localparam logic [3:0] PLAYER_STAND_MIN = 4'd6;
    localparam logic [3:0] BANKER_STAND     = 4'd7;

    // Tens and face cards count zero.
    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 4'd0 : rank;
    endfunction

endpackage

// File: rtl/baccarat_sequencer_banker_rule.sv
// -----------------------------------------------------------------------------
// banker_rule
// Combinational banker third-card decision, used after the player has drawn.
// Ports:
//   dscore  in 4 : banker two-card total (0..7 meaningful here)
//   pvalue  in 4 : point value (0..9) of the player's third card
//   draw    out 1: banker takes a third card
// -----------------------------------------------------------------------------
module banker_rule
    import baccarat_pkg::*;
(
    input  logic [3:0] dscore,
    input  logic [3:0] pvalue,
    output logic       draw
);

    always_comb begin
        draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (pvalue != 4'd8);
            4'd4:             draw = (pvalue >= 4'd2) && (pvalue <= 4'd7);
            4'd5:             draw = (pvalue >= 4'd4) && (pvalue <= 4'd7);
            4'd6:             draw = (pvalue >= 4'd6) && (pvalue <= 4'd7);
            // BANKER_STAND and above: never draws.
            default:          draw = 1'b0;
        endcase
    end

endmodule

// File: rtl/baccarat_sequencer.sv
// -----------------------------------------------------------------------------
// baccarat_sequencer
// Sequences one baccarat hand: issues card-register load strobes in dealing
// order, applies the player and banker third-card rules, shows the result and
// clears the card registers before the next hand.
// Ports:
//   slow_clock        in  : clock, rising edge
//   resetb            in  : asynchronous active-low reset
//   advance           in  : deal-step request
//   pscore, dscore    in 4: player / dealer totals from the score datapath
//   pcard3            in 4: raw rank of player card 3
//   load_pcard1..3    out : player card register load enables (Mealy)
//   load_dcard1..3    out : dealer card register load enables (Mealy)
//   clear_cards       out : clear all card registers (Mealy, from DONE)
//   player_win_light  out : player won or tie (DONE only)
//   dealer_win_light  out : dealer won or tie (DONE only)
//   hand_done         out : hand complete, lights valid
// -----------------------------------------------------------------------------
module baccarat_sequencer
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       advance,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_cards,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       hand_done
);

    state_t state_q, state_d;
    logic   banker_draw;

    banker_rule u_banker_rule (
        .dscore (dscore),
        .pvalue (card_value(pcard3)),
        .draw   (banker_draw)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) state_q <= DEAL_P1;
        else         state_q <= state_d;
    end

    // Next state and output decode. Strobes are gated by advance so each deal
    // state produces exactly one load on the edge that leaves it.
    always_comb begin
        state_d          = state_q;
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        clear_cards      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        hand_done        = 1'b0;
        case (state_q)
            DEAL_P1: if (advance) begin load_pcard1 = 1'b1; state_d = DEAL_D1; end
            DEAL_D1: if (advance) begin load_dcard1 = 1'b1; state_d = DEAL_P2; end
            DEAL_P2: if (advance) begin load_pcard2 = 1'b1; state_d = DEAL_D2; end
            DEAL_D2: if (advance) begin load_dcard2 = 1'b1; state_d = EVAL;    end
            // Scores reflect the second cards here, one cycle after the load.
            EVAL: begin
                if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN)
                    state_d = DONE;
                else if (pscore < PLAYER_STAND_MIN)
                    state_d = DEAL_P3;
                else if (dscore < PLAYER_STAND_MIN)
                    state_d = DEAL_D3;
                else
                    state_d = DONE;
            end
            DEAL_P3: if (advance) begin load_pcard3 = 1'b1; state_d = BANK_EVAL; end
            BANK_EVAL: state_d = banker_draw ? DEAL_D3 : DONE;
            DEAL_D3: if (advance) begin load_dcard3 = 1'b1; state_d = DONE; end
            DONE: begin
                hand_done        = 1'b1;
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
                if (advance) begin
                    clear_cards = 1'b1;
                    state_d     = DEAL_P1;
                end
            end
            default: state_d = DEAL_P1;
        endcase
    end

endmodule
